mmreq_regbus_bridge: RTL and testbench

- Consumes the host-to-FPGA 32-bit memory-mapped request stream (the FIFO fed by the core's user_w_mmreq channel).
- Executes each request as a single register-bus read or write transaction.
- Pushes read results, and optionally write acknowledgements, into the FPGA-to-host response FIFO drained by the core's user_r_mmresp channel.
- Sits between the Xillybus FIFOs and the design's register slaves, in the bus_clk domain.

---
 rtl/mmreq_regbus_bridge_if.sv | 29 ++
 rtl/mmreq_regbus_bridge.sv | 129 ++++++++++++
 tb/tb_mmreq_regbus_bridge.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmreq_regbus_bridge_if.sv
// Request/response FIFO and register-bus signals of the mmreq bridge.
// The master modport is the bridge side; the slave modport is the FIFOs plus register slaves.
interface mmreq_regbus_bridge_if #(
    parameter int ADDR_W = 20
);
    logic [31:0]       req_dout;
    logic              req_empty;
    logic              req_rd_en;
    logic              req_open;
    logic [31:0]       resp_din;
    logic              resp_wr_en;
    logic              resp_full;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [31:0]       reg_rdata;
    logic              reg_ack;

    modport master (
        input  req_dout, req_empty, req_open, resp_full, reg_rdata, reg_ack,
        output req_rd_en, resp_din, resp_wr_en, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport slave (
        output req_dout, req_empty, req_open, resp_full, reg_rdata, reg_ack,
        input  req_rd_en, resp_din, resp_wr_en, reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/mmreq_regbus_bridge.sv
// Executes host memory-mapped requests from the Xillybus request FIFO as register-bus transactions.
// Optional macro MMREQ_WRITE_ACK_EN: every completed write also pushes a status word (0 = ack, 1 = timeout).
module mmreq_regbus_bridge #(
    parameter int          ADDR_W       = 20,
    parameter int          TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_WORD = 32'hBAD0_ACC5
) (
    input  logic                  bus_clk,
    input  logic                  bus_reset_n,
    mmreq_regbus_bridge_if.master bus,
    output logic                  timeout_flag
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GET_DATA, BUS, RESP} state_t;

    state_t            state;
    logic              is_write;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_word;
    logic              wr_q;
    logic              rd_q;
    logic [15:0]       cnt;
    logic              req_pop;
    logic              resp_push;
    logic              resp_due;
    logic              bus_done;
    logic              unused_hdr_bits;

    assign unused_hdr_bits = ^bus.req_dout[30:ADDR_W];

    // Pops and pushes are decided from the registered state so the FWFT head word is consumed in the same cycle it is latched.
    always_comb begin
        req_pop   = bus_reset_n && bus.req_open && !bus.req_empty &&
                    ((state == IDLE) || (state == GET_DATA));
        resp_push = bus_reset_n && bus.req_open && !bus.resp_full && (state == RESP);
        bus_done  = bus.reg_ack || (cnt == CNT_LAST);
`ifdef MMREQ_WRITE_ACK_EN
        resp_due  = 1'b1;
`else
        resp_due  = !is_write;
`endif
    end

    assign bus.req_rd_en  = req_pop;
    assign bus.resp_wr_en = resp_push;
    assign bus.resp_din   = resp_word;
    assign bus.reg_addr   = addr_q;
    assign bus.reg_wdata  = wdata_q;
    assign bus.reg_wr     = wr_q;
    assign bus.reg_rd     = rd_q;

    always_ff @(posedge bus_clk) begin
        if (!bus_reset_n) begin
            state        <= IDLE;
            is_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_word    <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_pop) begin
                        addr_q   <= bus.req_dout[ADDR_W-1:0];
                        is_write <= bus.req_dout[31];
                        if (bus.req_dout[31]) begin
                            state <= GET_DATA;
                        end else begin
                            rd_q  <= 1'b1;
                            state <= BUS;
                        end
                    end
                end

                // A close here throws away the half-received write so a reopen starts on a header.
                GET_DATA: begin
                    if (!bus.req_open) begin
                        state <= IDLE;
                    end else if (!bus.req_empty) begin
                        wdata_q <= bus.req_dout;
                        wr_q    <= 1'b1;
                        state   <= BUS;
                    end
                end

                // Ack wins over timeout when both land on the same cycle.
                BUS: begin
                    cnt <= cnt + 16'd1;
                    if (bus_done) begin
                        wr_q <= 1'b0;
                        rd_q <= 1'b0;
                        cnt  <= '0;
                        if (!bus.reg_ack) begin
                            timeout_flag <= 1'b1;
                        end
                        if (!is_write) begin
                            resp_word <= bus.reg_ack ? bus.reg_rdata : TIMEOUT_WORD;
                        end
`ifdef MMREQ_WRITE_ACK_EN
                        else begin
                            resp_word <= bus.reg_ack ? 32'h0000_0000 : 32'h0000_0001;
                        end
`endif
                        if (resp_due && bus.req_open) begin
                            state <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                RESP: begin
                    if (!bus.req_open || !bus.resp_full) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmreq_regbus_bridge.sv
// Directed bench for mmreq_regbus_bridge: models both FIFOs and an auto-acking register slave,
// runs a table of single transactions, then hand-written timeout/back-pressure/close/reset sequences.
module tb_mmreq_regbus_bridge;

`ifdef MMREQ_WRITE_ACK_EN
    localparam int WACK = 1;
`else
    localparam int WACK = 0;
`endif
    localparam logic [31:0] NO_RESP      = 32'hFFFF_FFFF;
    localparam logic [31:0] WACK_OK_WORD = (WACK != 0) ? 32'h0000_0000 : NO_RESP;
    localparam logic [31:0] WACK_TO_WORD = (WACK != 0) ? 32'h0000_0001 : NO_RESP;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] data;
        int          ack_delay;
        logic [31:0] rdata;
        logic [19:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_rd;
        int          exp_wr;
        int          exp_resp;
        logic [31:0] exp_word;
    } vec_t;

    logic bus_clk;
    logic bus_reset_n;
    logic timeout_flag;

    mmreq_regbus_bridge_if #(.ADDR_W(20)) ifc ();

    mmreq_regbus_bridge #(
        .ADDR_W      (20),
        .TIMEOUT     (8),
        .TIMEOUT_WORD(32'hBAD0_ACC5)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset_n (bus_reset_n),
        .bus         (ifc.master),
        .timeout_flag(timeout_flag)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    logic [31:0] req_q[$];
    logic [31:0] resp_q[$];
    int          total_checks = 0;
    int          passed_checks = 0;
    int          cyc = 0;
    int          rd_cycles, wr_cycles, strobe_starts, viol;
    int          last_pop_cyc, first_strobe_cyc, ack_cyc, push_cyc;
    logic [19:0] seen_addr;
    logic [31:0] seen_wdata;
    logic        prev_rd, prev_wr;
    int          ack_delay, age;
    logic [31:0] slave_rdata;
    vec_t        vecs[5];

    task automatic refreshFifo();
        ifc.req_empty = (req_q.size() == 0);
        ifc.req_dout  = (req_q.size() != 0) ? req_q[0] : 32'h0;
    endtask

    task automatic pushReq(input logic [31:0] w);
        req_q.push_back(w);
        refreshFifo();
    endtask

    task automatic clearStats();
        rd_cycles        = 0;
        wr_cycles        = 0;
        strobe_starts    = 0;
        last_pop_cyc     = -1;
        first_strobe_cyc = -1;
        ack_cyc          = -1;
        push_cyc         = -1;
        resp_q.delete();
    endtask

    // One bus_clk cycle: sample at negedge, then update FIFO models and the slave just after posedge.
    task automatic cycle();
        logic s_rd, s_wr, s_pop, s_push;
        logic [31:0] s_din;
        @(negedge bus_clk);
        cyc++;
        s_rd   = ifc.reg_rd;
        s_wr   = ifc.reg_wr;
        s_pop  = ifc.req_rd_en;
        s_push = ifc.resp_wr_en;
        s_din  = ifc.resp_din;
        if (s_rd) rd_cycles++;
        if (s_wr) wr_cycles++;
        if (s_rd && s_wr) viol++;
        if ((s_rd && !prev_rd) || (s_wr && !prev_wr)) begin
            strobe_starts++;
            first_strobe_cyc = cyc;
            seen_addr        = ifc.reg_addr;
            seen_wdata       = ifc.reg_wdata;
        end else if ((s_rd || s_wr) && ((ifc.reg_addr != seen_addr) || (ifc.reg_wdata != seen_wdata))) begin
            viol++;
        end
        if (s_pop) begin
            if (req_q.size() == 0) viol++;
            last_pop_cyc = cyc;
        end
        if (s_push) begin
            if (ifc.resp_full) viol++;
            push_cyc = cyc;
        end
        if (ifc.reg_ack) ack_cyc = cyc;
        prev_rd = s_rd;
        prev_wr = s_wr;
        @(posedge bus_clk);
        #1;
        if (s_pop && (req_q.size() != 0)) void'(req_q.pop_front());
        if (s_push) resp_q.push_back(s_din);
        refreshFifo();
        if (ifc.reg_ack) begin
            ifc.reg_ack   = 1'b0;
            ifc.reg_rdata = 32'h0;
            age           = 0;
        end else if (s_rd || s_wr) begin
            age++;
            if ((ack_delay != 0) && (age == ack_delay)) begin
                ifc.reg_ack   = 1'b1;
                ifc.reg_rdata = slave_rdata;
            end
        end else begin
            age = 0;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    function automatic logic [31:0] firstResp();
        return (resp_q.size() != 0) ? resp_q[0] : NO_RESP;
    endfunction

    task automatic applyStimulus(input vec_t v);
        ack_delay   = v.ack_delay;
        slave_rdata = v.rdata;
        pushReq(v.hdr);
        if (v.hdr[31]) pushReq(v.data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_1234, 32'h0, 3, 32'hCAFE_F00D, 20'h01234, 32'h0, 4, 0, 1, 32'hCAFE_F00D};
        vecs[1] = '{32'h8000_0010, 32'h1122_3344, 1, 32'h0, 20'h00010, 32'h1122_3344, 0, 2, WACK, WACK_OK_WORD};
        vecs[2] = '{32'h7FFA_BCDE, 32'h0, 1, 32'h5A5A_0001, 20'hABCDE, 32'h0, 2, 0, 1, 32'h5A5A_0001};
        vecs[3] = '{32'hC00F_FFFF, 32'hDEAD_BEEF, 2, 32'h0, 20'hFFFFF, 32'hDEAD_BEEF, 0, 3, WACK, WACK_OK_WORD};
        vecs[4] = '{32'h0000_0000, 32'h0, 7, 32'h1357_9BDF, 20'h00000, 32'h0, 8, 0, 1, 32'h1357_9BDF};

        bus_reset_n   = 1'b0;
        ifc.req_open  = 1'b0;
        ifc.resp_full = 1'b0;
        ifc.reg_ack   = 1'b0;
        ifc.reg_rdata = 32'h0;
        prev_rd = 1'b0; prev_wr = 1'b0;
        viol = 0; age = 0; ack_delay = 0; slave_rdata = 32'h0;
        seen_addr = '0; seen_wdata = '0;
        refreshFifo();
        clearStats();
        runCycles(2);

        checkOutput("reset_reg_rd", 32'(ifc.reg_rd), 0);
        checkOutput("reset_reg_wr", 32'(ifc.reg_wr), 0);
        checkOutput("reset_resp_wr_en", 32'(ifc.resp_wr_en), 0);
        checkOutput("reset_reg_addr", 32'(ifc.reg_addr), 0);
        checkOutput("reset_timeout_flag", 32'(timeout_flag), 0);

        bus_reset_n  = 1'b1;
        ifc.req_open = 1'b1;
        runCycles(1);

        for (int i = 0; i < 5; i++) begin
            clearStats();
            applyStimulus(vecs[i]);
            runCycles(20);
            checkOutput($sformatf("v%0d_rd_cycles", i), rd_cycles, vecs[i].exp_rd);
            checkOutput($sformatf("v%0d_wr_cycles", i), wr_cycles, vecs[i].exp_wr);
            checkOutput($sformatf("v%0d_addr", i), 32'(seen_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].hdr[31]) checkOutput($sformatf("v%0d_wdata", i), seen_wdata, vecs[i].exp_wdata);
            checkOutput($sformatf("v%0d_strobe_latency", i), first_strobe_cyc - last_pop_cyc, 1);
            checkOutput($sformatf("v%0d_resp_count", i), resp_q.size(), vecs[i].exp_resp);
            checkOutput($sformatf("v%0d_resp_word", i), firstResp(), vecs[i].exp_word);
            if (vecs[i].exp_resp != 0) checkOutput($sformatf("v%0d_resp_latency", i), push_cyc - ack_cyc, 1);
            checkOutput($sformatf("v%0d_req_drained", i), req_q.size(), 0);
            checkOutput($sformatf("v%0d_timeout_flag", i), 32'(timeout_flag), 0);
        end

        // Read timeout, then a write timeout, then a good read with the sticky flag still set.
        clearStats();
        ack_delay = 0;
        pushReq(32'h0000_0020);
        runCycles(20);
        checkOutput("to_rd_cycles", rd_cycles, 8);
        checkOutput("to_resp_count", resp_q.size(), 1);
        checkOutput("to_resp_word", firstResp(), 32'hBAD0_ACC5);
        checkOutput("to_flag_set", 32'(timeout_flag), 1);

        clearStats();
        pushReq(32'h8000_0100);
        pushReq(32'h0000_00FF);
        runCycles(20);
        checkOutput("to_wr_cycles", wr_cycles, 8);
        checkOutput("to_wr_resp_word", firstResp(), WACK_TO_WORD);

        clearStats();
        ack_delay = 1; slave_rdata = 32'h0000_BEEF;
        pushReq(32'h0000_0030);
        runCycles(15);
        checkOutput("to_good_resp", firstResp(), 32'h0000_BEEF);
        checkOutput("to_flag_sticky", 32'(timeout_flag), 1);

        // Response back-pressure holds the response and blocks further pops.
        clearStats();
        ifc.resp_full = 1'b1;
        ack_delay = 2; slave_rdata = 32'hA5A5_0100;
        pushReq(32'h0000_0100);
        pushReq(32'h0000_0200);
        runCycles(25);
        checkOutput("bp_no_push", resp_q.size(), 0);
        checkOutput("bp_no_pop", req_q.size(), 1);
        checkOutput("bp_one_txn", strobe_starts, 1);
        ifc.resp_full = 1'b0;
        begin
            int exp_push;
            exp_push = cyc + 1;
            cycle();
            checkOutput("bp_push_cycle", push_cyc, exp_push);
        end
        checkOutput("bp_push_word", firstResp(), 32'hA5A5_0100);
        runCycles(15);
        checkOutput("bp_total_resp", resp_q.size(), 2);

        // Close mid-write: header only, closed FIFO must not pop, reopen with a read.
        clearStats();
        ack_delay = 1; slave_rdata = 32'h0000_0888;
        pushReq(32'h8000_0004);
        runCycles(3);
        ifc.req_open = 1'b0;
        runCycles(2);
        pushReq(32'h0000_0008);
        runCycles(3);
        checkOutput("close_no_pop", req_q.size(), 1);
        ifc.req_open = 1'b1;
        runCycles(15);
        checkOutput("close_no_write", wr_cycles, 0);
        checkOutput("close_one_read", strobe_starts, 1);
        checkOutput("close_read_addr", 32'(seen_addr), 32'h8);
        checkOutput("close_resp", firstResp(), 32'h0000_0888);

        // Reset while a read strobe is active.
        clearStats();
        ack_delay = 0;
        pushReq(32'h0000_0050);
        for (int k = 0; (k < 10) && !ifc.reg_rd; k++) cycle();
        checkOutput("rst_reached_bus", 32'(ifc.reg_rd), 1);
        pushReq(32'h0000_0040);
        bus_reset_n = 1'b0;
        cycle();
        checkOutput("rst_reg_rd", 32'(ifc.reg_rd), 0);
        checkOutput("rst_reg_wr", 32'(ifc.reg_wr), 0);
        checkOutput("rst_req_rd_en", 32'(ifc.req_rd_en), 0);
        checkOutput("rst_resp_wr_en", 32'(ifc.resp_wr_en), 0);
        checkOutput("rst_reg_addr", 32'(ifc.reg_addr), 0);
        checkOutput("rst_reg_wdata", ifc.reg_wdata, 0);
        checkOutput("rst_resp_din", ifc.resp_din, 0);
        checkOutput("rst_timeout_flag", 32'(timeout_flag), 0);
        checkOutput("rst_no_pop", req_q.size(), 1);
        clearStats();
        ack_delay = 1; slave_rdata = 32'h0000_4040;
        bus_reset_n = 1'b1;
        runCycles(20);
        checkOutput("rst_after_addr", 32'(seen_addr), 32'h40);
        checkOutput("rst_after_rd_cycles", rd_cycles, 2);
        checkOutput("rst_after_resp", firstResp(), 32'h0000_4040);

        checkOutput("protocol_violations", viol, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
